// File: rtl/bpod_cmd_pkg.sv
// rtl/bpod_cmd_pkg.sv - shared states, error codes and defaults for the Bpod command parser
package bpod_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OP      = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CHK  = 3'd2;
    localparam logic [2:0] ERR_TMO  = 3'd3;
    localparam logic [2:0] ERR_BUSY = 3'd4;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_payload_ram.sv
// rtl/cmd_payload_ram.sv - payload buffer, one sync write and one sync read port, no reset
module cmd_payload_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/bpod_cmd_parser.sv
// rtl/bpod_cmd_parser.sv - HDR/OP/LEN/payload/CHK byte framer with held command output
// Optional inter-byte timeout is built when CMD_PARSER_TIMEOUT_EN is defined.
module bpod_cmd_parser
    import bpod_cmd_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] HDR         = HDR_DEFAULT,
    localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          cmd_valid,
    output logic [7:0]    cmd_op,
    output logic [7:0]    cmd_len,
    input  logic          cmd_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_valid,
    output logic [2:0]    err_code
);

    state_e     state_q;
    logic [7:0] op_q, len_q, idx_q, acc_q;
    logic [7:0] cmd_op_q, cmd_len_q;
    logic       cmd_valid_q, err_valid_q, expose_q;
    logic [2:0] err_code_q;
    logic [7:0] ram_rdata;
    logic       ram_we_d;

    assign ram_we_d = rx_valid && (state_q == ST_PAYLOAD);

    cmd_payload_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we_d),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (rx_data),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            cmd_op_q    <= '0;
            cmd_len_q   <= '0;
            cmd_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            expose_q    <= 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            err_valid_q <= 1'b0;
            expose_q    <= cmd_valid_q;
            if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == HDR) begin
                            state_q <= ST_OP;
                            acc_q   <= '0;
                        end
                    end
                    ST_OP: begin
                        op_q    <= rx_data;
                        acc_q   <= acc_q ^ rx_data;
                        state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        len_q <= rx_data;
                        acc_q <= acc_q ^ rx_data;
                        idx_q <= '0;
                        if (rx_data > 8'(MAX_LEN)) begin
                            state_q     <= ST_IDLE;
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                        end else if (rx_data == 8'd0) begin
                            state_q <= ST_CHK;
                        end else begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        acc_q <= acc_q ^ rx_data;
                        idx_q <= idx_q + 8'd1;
                        if ((idx_q + 8'd1) == len_q) begin
                            state_q <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_data == acc_q) begin
                            state_q     <= ST_HOLD;
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= op_q;
                            cmd_len_q   <= len_q;
                        end else begin
                            state_q     <= ST_IDLE;
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end
                    end
                    ST_HOLD: begin
                        // An ack in the same cycle frees the parser before the byte is judged.
                        if (cmd_ack) begin
                            cmd_valid_q <= 1'b0;
                            if (rx_data == HDR) begin
                                state_q <= ST_OP;
                                acc_q   <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_BUSY;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q == ST_HOLD && cmd_ack) begin
                cmd_valid_q <= 1'b0;
                state_q     <= ST_IDLE;
            end
`ifdef CMD_PARSER_TIMEOUT_EN
            if (rx_valid || state_q == ST_IDLE || state_q == ST_HOLD) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_q       <= '0;
                state_q     <= ST_IDLE;
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_TMO;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_len   = cmd_len_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    // Buffer contents are only meaningful while a command is held.
    assign rd_data   = expose_q ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_bpod_cmd_parser.sv
// tb/tb_bpod_cmd_parser.sv - scoreboard bench with queue-based frame model for bpod_cmd_parser
module tb_bpod_cmd_parser;

    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 100;
    localparam int         AW      = 4;
    localparam logic [7:0] HDR     = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          cmd_valid;
    logic [7:0]    cmd_op, cmd_len;
    logic          cmd_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          err_valid;
    logic [2:0]    err_code;

    bpod_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO), .HDR(HDR)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_ack(cmd_ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [7:0] op;
        logic [7:0] len;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] fr[$];
    logic [7:0] mpl[$];
    bit         pend = 0;
    bit         got_cmd = 0;
    bit         ack_next = 0;
    logic [2:0] mon_code = 3'd0;
    logic [7:0] held_op = '0, held_len = '0;
    bit         cv_prev = 0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_err(input logic [2:0] c);
        ev_t e;
        e.is_err = 1; e.code = c; e.op = '0; e.len = '0;
        sb.push_back(e);
    endtask

    // Reference: collect the frame as a byte list and judge it once complete.
    task automatic model_byte(input logic [7:0] b, input bit ack);
        ev_t        e;
        logic [7:0] x;
        if (pend && ack) pend = 0;
        if (pend) begin
            push_err(3'd4);
            return;
        end
        if (fr.size() == 0) begin
            if (b == HDR) fr.push_back(b);
            return;
        end
        fr.push_back(b);
        if (fr.size() == 3 && int'(fr[2]) > MAX_LEN) begin
            push_err(3'd1);
            fr.delete();
            return;
        end
        if (fr.size() >= 3 && fr.size() == 4 + int'(fr[2])) begin
            x = '0;
            for (int i = 1; i < fr.size() - 1; i++) x ^= fr[i];
            if (x == b) begin
                e.is_err = 0; e.code = '0; e.op = fr[1]; e.len = fr[2];
                sb.push_back(e);
                mpl.delete();
                for (int i = 0; i < int'(fr[2]); i++) mpl.push_back(fr[3 + i]);
                pend = 1;
                got_cmd = 1;
            end else begin
                push_err(3'd2);
            end
            fr.delete();
        end
    endtask

    task automatic read_payload();
        for (int i = 0; i < mpl.size(); i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            chk("rd_data", {24'd0, rd_data}, {24'd0, mpl[i]});
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        model_byte(b, ack_next);
        rx_data  = b;
        rx_valid = 1'b1;
        cmd_ack  = ack_next;
        ack_next = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        if (got_cmd) begin
            got_cmd = 0;
            read_payload();
        end
    endtask

    task automatic ack_only();
        pend = 0;
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        chk("ack_drop", {31'd0, cmd_valid}, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] op, input int len, input bit corrupt);
        logic [7:0] q[$];
        logic [7:0] x, b;
        q.push_back(HDR); q.push_back(op); q.push_back(8'(len));
        x = op ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x ^= b;
        end
        q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
        foreach (q[i]) send_b(q[i]);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        fr.delete();
        pend = 0;
        ack_next = 0;
        mon_code = 3'd0;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            cv_prev = 0;
        end else begin
            if (err_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_err", {29'd0, err_code}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ev_is_err", {31'd0, e.is_err}, 32'd1);
                    chk("err_code_evt", {29'd0, err_code}, {29'd0, e.code});
                    mon_code = e.code;
                end
            end
            if (cmd_valid && !cv_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd", {24'd0, cmd_op}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ev_is_cmd", {31'd0, e.is_err}, 32'd0);
                    held_op  = e.op;
                    held_len = e.len;
                end
            end
            if (cmd_valid) begin
                chk("cmd_op", {24'd0, cmd_op}, {24'd0, held_op});
                chk("cmd_len", {24'd0, cmd_len}, {24'd0, held_len});
            end
            chk("err_code_hold", {29'd0, err_code}, {29'd0, mon_code});
            cv_prev = cmd_valid;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd_op", {24'd0, cmd_op}, 32'd0);
        chk("rst_cmd_len", {24'd0, cmd_len}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("rst_err_code", {29'd0, err_code}, 32'd0);
        do_reset(0);
        @(negedge clk);

        // Good frame, busy byte, ack together with a zero-length frame, plain ack.
        send_b(8'hA5); send_b(8'h10); send_b(8'h02); send_b(8'h11); send_b(8'h22); send_b(8'h21);
        chk("tp_valid", {31'd0, cmd_valid}, 32'd1);
        chk("tp_op", {24'd0, cmd_op}, 32'h10);
        chk("tp_len", {24'd0, cmd_len}, 32'h2);
        send_b(8'hA5);
        chk("busy_keep", {24'd0, cmd_op}, 32'h10);
        ack_next = 1;
        send_b(8'hA5); send_b(8'h07); send_b(8'h00); send_b(8'h07);
        chk("zero_len", {24'd0, cmd_len}, 32'h0);
        chk("zero_op", {24'd0, cmd_op}, 32'h07);
        ack_only();

        // Bad checksum followed by a good frame; over-length then a stray byte.
        send_b(8'hA5); send_b(8'h10); send_b(8'h02); send_b(8'h11); send_b(8'h22); send_b(8'h20);
        send_frame(8'h33, 3, 0);
        ack_only();
        send_b(8'hA5); send_b(8'h01); send_b(8'h11); send_b(8'h5A);
        send_frame(8'h44, MAX_LEN, 0);
        ack_only();

        // Stall after the opcode.
        send_b(8'hA5); send_b(8'h10);
`ifdef CMD_PARSER_TIMEOUT_EN
        fr.delete();
        push_err(3'd3);
`endif
        repeat (TMO + 10) @(negedge clk);
        send_b(8'h00); send_b(8'h10);
        if (pend) ack_only();
        send_frame(8'h55, 1, 0);
        ack_only();

        // Reset in mid-frame discards the partial frame silently.
        send_b(8'hA5); send_b(8'h10); send_b(8'h02); send_b(8'h11);
        do_reset(2);
        @(negedge clk);
        chk("midrst_err", {29'd0, err_code}, 32'd0);
        send_frame(8'h66, 2, 0);
        ack_only();

        for (int it = 0; it < 150; it++) begin
            int k;
            if (pend) begin
                if ($urandom_range(0, 2) == 0) send_b(8'($urandom));
                if ($urandom_range(0, 1) == 0) ack_only();
                else ack_next = 1;
            end
            k = $urandom_range(0, 9);
            if (k == 0) send_b(8'($urandom));
            else if (k == 1) begin
                send_b(HDR); send_b(8'($urandom)); send_b(8'($urandom_range(MAX_LEN + 1, 255)));
            end else if (k == 2) send_frame(8'($urandom), $urandom_range(0, MAX_LEN), 1);
            else send_frame(8'($urandom), $urandom_range(0, MAX_LEN), 0);
        end
        if (pend) ack_only();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
